ff_bus_ctrl: RTL and testbench

FF_BUS_CTRL -- requirements
Module: ff_bus_ctrl

---
 rtl/ff_bus_pkg.sv | 47 ++++
 rtl/ff_irq_prio.sv | 42 ++++
 rtl/ff_bus_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ff_bus_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ff_bus_pkg.sv
// Shared definitions for the 68000-style bus controller: address map, FSM
// states, interrupt levels and the region decoder.
package ff_bus_pkg;

  localparam int ADDR_W = 24;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] ROM_BASE = 24'h000000;
  localparam logic [ADDR_W-1:0] ROM_MASK = 24'hFF0000;
  localparam logic [ADDR_W-1:0] RAM_BASE = 24'h010000;
  localparam logic [ADDR_W-1:0] RAM_MASK = 24'hFF0000;
  localparam logic [ADDR_W-1:0] IO_BASE  = 24'h800000;
  localparam logic [ADDR_W-1:0] IO_MASK  = 24'hF00000;

  localparam logic [2:0] FC_IACK     = 3'b111;
  localparam logic [2:0] IRQ_LVL_VBL = 3'd1;
  localparam logic [2:0] IRQ_LVL_32V = 3'd2;
  localparam logic [2:0] IPL_NONE    = 3'b111;
  localparam logic [2:0] IPL_LVL1    = 3'b110;
  localparam logic [2:0] IPL_LVL2    = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_IACK,
    ST_ERR,
    ST_TMO
  } bus_state_e;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_IO
  } region_e;

  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    region_e r;
    if ((addr & ROM_MASK) == ROM_BASE)      r = REG_ROM;
    else if ((addr & RAM_MASK) == RAM_BASE) r = REG_RAM;
    else if ((addr & IO_MASK) == IO_BASE)   r = REG_IO;
    else                                    r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/ff_irq_prio.sv
// Interrupt pending latches with set-over-clear priority and a registered
// active-low level encoder for the CPU IPL pins.
module ff_irq_prio
  import ff_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       irq_vbl,
  input  logic       irq_32v,
  input  logic       clr_lvl1,
  input  logic       clr_lvl2,
  output logic [2:0] ipl
);

  logic       pend1_q, pend1_d;
  logic       pend2_q, pend2_d;
  logic [2:0] ipl_q, ipl_d;

  // A new pulse on the same edge as the acknowledge keeps the request alive.
  always_comb begin
    pend1_d = irq_vbl | (pend1_q & ~clr_lvl1);
    pend2_d = irq_32v | (pend2_q & ~clr_lvl2);
    if (pend2_d)      ipl_d = IPL_LVL2;
    else if (pend1_d) ipl_d = IPL_LVL1;
    else              ipl_d = IPL_NONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      ipl_q   <= IPL_NONE;
    end else begin
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      ipl_q   <= ipl_d;
    end
  end

  assign ipl = ipl_q;

endmodule

// File: rtl/ff_bus_ctrl.sv
// Bus controller: decodes CPU cycles into region selects, inserts wait
// states, generates DTACK/VPA/BERR and hosts the interrupt priority logic.
module ff_bus_ctrl
  import ff_bus_pkg::*;
#(
  parameter int ROM_WAIT     = 0,
  parameter int RAM_WAIT     = 0,
  parameter int IO_WAIT      = 2,
  parameter int BERR_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_in,
  input  logic              as_n,
  input  logic              uds_n,
  input  logic              lds_n,
  input  logic              r_w_n,
  input  logic [2:0]        fc,
  input  logic              irq_vbl,
  input  logic              irq_32v,
  output logic              dtack_n,
  output logic              vpa_n,
  output logic              berr_n,
  output logic [2:0]        ipl,
  output logic              rom_cs,
  output logic              ram_cs,
  output logic              io_cs,
  output logic              wr_en
);

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cs_q, cs_d;
  logic             dtack_q, dtack_d;
  logic             vpa_q, vpa_d;
  logic             berr_q, berr_d;
  logic             as_rdy_q;
  logic             clr_lvl1, clr_lvl2;

  region_e          region;
  logic [CNT_W-1:0] acc_wait;
  logic [2:0]       acc_cs;

  always_comb begin
    region   = decode_region(a_in);
    acc_wait = '0;
    acc_cs   = 3'b000;
    case (region)
      REG_ROM: begin acc_wait = CNT_W'(ROM_WAIT); acc_cs = 3'b001; end
      REG_RAM: begin acc_wait = CNT_W'(RAM_WAIT); acc_cs = 3'b010; end
      REG_IO:  begin acc_wait = CNT_W'(IO_WAIT);  acc_cs = 3'b100; end
      default: begin acc_wait = '0;               acc_cs = 3'b000; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    dtack_d  = dtack_q;
    vpa_d    = vpa_q;
    berr_d   = berr_q;
    clr_lvl1 = 1'b0;
    clr_lvl2 = 1'b0;
    case (state_q)
      // as_rdy_q blocks a strobe still held low across reset release.
      ST_IDLE: begin
        if (!as_n && as_rdy_q) begin
          if (fc == FC_IACK) begin
            state_d  = ST_IACK;
            clr_lvl1 = (a_in[3:1] == IRQ_LVL_VBL);
            clr_lvl2 = (a_in[3:1] == IRQ_LVL_32V);
          end else if (region == REG_NONE) begin
            if (BERR_TIMEOUT == 0) begin
              state_d = ST_ERR;
              berr_d  = 1'b0;
            end else begin
              state_d = ST_TMO;
              cnt_d   = CNT_W'(BERR_TIMEOUT);
            end
          end else begin
            cs_d = acc_cs;
            if (acc_wait == '0) begin
              state_d = ST_ACK;
              dtack_d = 1'b0;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = acc_wait;
            end
          end
        end
      end
      ST_WAIT: begin
        if (as_n) begin
          state_d = ST_IDLE;
          cs_d    = 3'b000;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ACK;
          dtack_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (as_n) begin
          state_d = ST_IDLE;
          cs_d    = 3'b000;
          dtack_d = 1'b1;
        end
      end
      ST_IACK: begin
        if (as_n) begin
          state_d = ST_IDLE;
          vpa_d   = 1'b1;
        end else begin
          vpa_d = 1'b0;
        end
      end
      ST_TMO: begin
        if (as_n) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ERR;
          berr_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ERR: begin
        if (as_n) begin
          state_d = ST_IDLE;
          berr_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 3'b000;
        dtack_d = 1'b1;
        vpa_d   = 1'b1;
        berr_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cs_q     <= 3'b000;
      dtack_q  <= 1'b1;
      vpa_q    <= 1'b1;
      berr_q   <= 1'b1;
      as_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      dtack_q  <= dtack_d;
      vpa_q    <= vpa_d;
      berr_q   <= berr_d;
      as_rdy_q <= as_rdy_q | as_n;
    end
  end

  ff_irq_prio u_irq_prio (
    .clk      (clk),
    .reset_n  (reset_n),
    .irq_vbl  (irq_vbl),
    .irq_32v  (irq_32v),
    .clr_lvl1 (clr_lvl1),
    .clr_lvl2 (clr_lvl2),
    .ipl      (ipl)
  );

  assign rom_cs  = cs_q[0];
  assign ram_cs  = cs_q[1];
  assign io_cs   = cs_q[2];
  assign dtack_n = dtack_q;
  assign vpa_n   = vpa_q;
  assign berr_n  = berr_q;
  assign wr_en   = (|cs_q) & ~r_w_n & (~uds_n | ~lds_n);

endmodule

// File: tb/tb_ff_bus_ctrl.sv
// Self-checking bench for ff_bus_ctrl: directed bus/interrupt scenarios then
// randomized traffic, checked against a cycle-count model of the bus rules.
module tb_ff_bus_ctrl;

  localparam int ROM_W = 0;
  localparam int RAM_W = 1;
  localparam int IO_W  = 2;
  localparam int TMO   = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] a_in;
  logic        as_n, uds_n, lds_n, r_w_n;
  logic [2:0]  fc;
  logic        irq_vbl, irq_32v;
  logic        dtack_n, vpa_n, berr_n;
  logic [2:0]  ipl;
  logic        rom_cs, ram_cs, io_cs, wr_en;

  int checksTotal  = 0;
  int checksFailed = 0;
  logic modelPend1 = 1'b0;
  logic modelPend2 = 1'b0;

  always #5 clk = ~clk;

  ff_bus_ctrl #(
    .ROM_WAIT     (ROM_W),
    .RAM_WAIT     (RAM_W),
    .IO_WAIT      (IO_W),
    .BERR_TIMEOUT (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a_in    (a_in),
    .as_n    (as_n),
    .uds_n   (uds_n),
    .lds_n   (lds_n),
    .r_w_n   (r_w_n),
    .fc      (fc),
    .irq_vbl (irq_vbl),
    .irq_32v (irq_32v),
    .dtack_n (dtack_n),
    .vpa_n   (vpa_n),
    .berr_n  (berr_n),
    .ipl     (ipl),
    .rom_cs  (rom_cs),
    .ram_cs  (ram_cs),
    .io_cs   (io_cs),
    .wr_en   (wr_en)
  );

  // Outputs are observed 2 time units after the rising edge they belong to.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [2:0] iplModel();
    if (modelPend2)      return 3'b101;
    else if (modelPend1) return 3'b110;
    else                 return 3'b111;
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checksTotal++;
    assert (obs === exp) else begin
      checksFailed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] expCs, input logic expWr,
                          input logic expDtack, input logic expVpa, input logic expBerr);
    checkOutput({tag, ".cs"},    {io_cs, ram_cs, rom_cs}, expCs);
    checkOutput({tag, ".wr"},    {2'b00, wr_en},   {2'b00, expWr});
    checkOutput({tag, ".dtack"}, {2'b00, dtack_n}, {2'b00, expDtack});
    checkOutput({tag, ".vpa"},   {2'b00, vpa_n},   {2'b00, expVpa});
    checkOutput({tag, ".berr"},  {2'b00, berr_n},  {2'b00, expBerr});
    checkOutput({tag, ".ipl"},   ipl, iplModel());
  endtask

  // Ordinary CPU cycle: strobe held low for holdCycles sampled edges.
  task automatic applyStimulus(input string tag, input logic [23:0] addr, input logic rw,
                               input logic u, input logic l, input int holdCycles);
    logic [2:0] expCs;
    int         waitN;
    logic       mapped;
    expCs  = 3'b000;
    waitN  = 0;
    mapped = 1'b1;
    if (addr <= 24'h00FFFF) begin
      expCs = 3'b001; waitN = ROM_W;
    end else if (addr <= 24'h01FFFF) begin
      expCs = 3'b010; waitN = RAM_W;
    end else if (addr >= 24'h800000 && addr <= 24'h8FFFFF) begin
      expCs = 3'b100; waitN = IO_W;
    end else begin
      mapped = 1'b0;
    end
    a_in = addr; r_w_n = rw; uds_n = u; lds_n = l; fc = 3'b101; as_n = 1'b0;
    for (int c = 0; c < holdCycles; c++) begin
      tick;
      if (mapped)
        checkAll(tag, expCs, ~rw & (~u | ~l), (c >= waitN) ? 1'b0 : 1'b1, 1'b1, 1'b1);
      else
        checkAll(tag, 3'b000, 1'b0, 1'b1, 1'b1, (c >= TMO) ? 1'b0 : 1'b1);
    end
    as_n = 1'b1;
    tick;
    checkAll({tag, ".end"}, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic irqPulse(input string tag, input logic vbl, input logic v32);
    irq_vbl = vbl;
    irq_32v = v32;
    tick;
    modelPend1 = modelPend1 | vbl;
    modelPend2 = modelPend2 | v32;
    irq_vbl = 1'b0;
    irq_32v = 1'b0;
    checkAll(tag, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic iackCycle(input string tag, input logic [2:0] level, input int holdCycles,
                           input logic vblAtEntry);
    a_in = {20'h00000, level, 1'b0};
    fc = 3'b111; r_w_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    irq_vbl = vblAtEntry;
    tick;
    if (level == 3'd1) modelPend1 = 1'b0;
    if (level == 3'd2) modelPend2 = 1'b0;
    modelPend1 = modelPend1 | vblAtEntry;
    irq_vbl = 1'b0;
    checkAll({tag, ".entry"}, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int c = 1; c < holdCycles; c++) begin
      tick;
      checkAll(tag, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    as_n = 1'b1;
    fc = 3'b101;
    tick;
    checkAll({tag, ".end"}, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    a_in = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; r_w_n = 1'b1; fc = 3'b101;
    irq_vbl = 1'b0; irq_32v = 1'b0;
    tick;
    checkAll("reset", 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b1;
    tick;
    checkAll("idle", 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);

    applyStimulus("rom_rd",   24'h000100, 1'b1, 1'b0, 1'b0, 3);
    applyStimulus("io_wr",    24'h800004, 1'b0, 1'b0, 1'b1, 4);
    applyStimulus("ram_wr",   24'h012346, 1'b0, 1'b1, 1'b0, 3);
    applyStimulus("ram_rd",   24'h01FFFE, 1'b1, 1'b0, 1'b0, 2);
    applyStimulus("io_abort", 24'h800010, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus("io_nostb", 24'h8FFFFE, 1'b0, 1'b1, 1'b1, 3);
    applyStimulus("berr",     24'h400000, 1'b1, 1'b0, 1'b0, 17);
    applyStimulus("tmo_abrt", 24'h020000, 1'b1, 1'b0, 1'b0, 5);

    irqPulse("irq_both", 1'b1, 1'b1);
    checkOutput("ipl_both", ipl, 3'b101);
    iackCycle("iack2", 3'd2, 3, 1'b0);
    checkOutput("ipl_after2", ipl, 3'b110);
    iackCycle("iack1", 3'd1, 3, 1'b0);
    checkOutput("ipl_after1", ipl, 3'b111);

    irqPulse("irq_vbl", 1'b1, 1'b0);
    iackCycle("iack1_set", 3'd1, 3, 1'b1);
    checkOutput("ipl_setwins", ipl, 3'b110);
    iackCycle("iack1_clr", 3'd1, 2, 1'b0);
    iackCycle("iack5", 3'd5, 2, 1'b0);

    irqPulse("irq_32v", 1'b0, 1'b1);
    a_in = 24'h800020; r_w_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; fc = 3'b101; as_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    modelPend1 = 1'b0;
    modelPend2 = 1'b0;
    checkAll("rst_mid", 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    tick;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      checkAll("post_rst", 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    as_n = 1'b1;
    tick;
    checkAll("post_rst_idle", 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("post_rst_io", 24'h800020, 1'b0, 1'b0, 1'b0, 3);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        logic [23:0] addr;
        int          waitN;
        case ($urandom_range(0, 3))
          0: begin addr = 24'($urandom_range(0, 32'h00FFFF));            waitN = ROM_W; end
          1: begin addr = 24'h010000 + 24'($urandom_range(0, 32'hFFFF)); waitN = RAM_W; end
          2: begin addr = 24'h800000 + 24'($urandom_range(0, 32'hFFFFF)); waitN = IO_W; end
          default: begin
            addr = 24'h020000 + 24'($urandom_range(0, 32'h7DFFFF));
            if ($urandom_range(0, 1) == 1) addr = 24'h900000 + 24'($urandom_range(0, 32'h6FFFFF));
            waitN = TMO;
          end
        endcase
        applyStimulus("rnd_acc", addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(1, waitN + 3));
      end else if (op == 2) begin
        irqPulse("rnd_irq", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        iackCycle("rnd_iack", 3'($urandom_range(0, 7)), $urandom_range(2, 4),
                  1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d/%0d checks passed", checksTotal - checksFailed, checksTotal);
    $finish;
  end

endmodule
